// File: rtl/nvdla_hls_shiftrightsu_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : nvdla_hls_shiftrightsu_pipe                                 |
// | Purpose  : multi-lane, two-stage valid/ready right shifter with        |
// |            per-beat signed/unsigned and round/truncate modes, and      |
// |            clamping to the narrower output width.                      |
// | Option   : NVDLA_HLS_SHIFTRIGHTSU_SAT_CNT_EN builds the saturation     |
// |            event counter (sat_cnt / sat_cnt_clr).                      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module nvdla_hls_shiftrightsu_pipe #(
  parameter int LANES         = 4,
  parameter int IN_WIDTH      = 49,
  parameter int OUT_WIDTH     = 32,
  parameter int SHIFT_WIDTH   = 6,
  parameter int SAT_CNT_WIDTH = 32
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rstn,
  input  logic                         in_pvld,
  output logic                         in_prdy,
  input  logic [LANES*IN_WIDTH-1:0]    in_data,
  input  logic [LANES*SHIFT_WIDTH-1:0] in_shift,
  input  logic                         in_unsigned,
  input  logic                         in_round_en,
  output logic                         out_pvld,
  input  logic                         out_prdy,
  output logic [LANES*OUT_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]             out_sat,
  input  logic                         sat_cnt_clr,
  output logic [SAT_CNT_WIDTH-1:0]     sat_cnt
);

  // Quotient keeps one extra bit so unsigned inputs stay non-negative;
  // the rounded value gets one more for the rounding carry.
  localparam int C_QW = IN_WIDTH + 1;
  localparam int C_RW = IN_WIDTH + 2;

  logic r_s1_vld;
  logic r_s2_vld;
  logic w_s1_adv;
  logic w_s1_load;
  logic w_s2_load;
  logic r_s1_uns;
  logic r_s1_rnd;

  logic [LANES-1:0][C_QW-1:0]      w_q;
  logic [LANES-1:0][C_QW-1:0]      r_q;
  logic [LANES-1:0]                w_guide;
  logic [LANES-1:0]                r_guide;
  logic [LANES-1:0]                w_sticky;
  logic [LANES-1:0]                r_sticky;
  logic [LANES-1:0]                w_neg;
  logic [LANES-1:0]                r_neg;
  logic [LANES-1:0]                w_oor;
  logic [LANES-1:0]                r_oor;
  logic [LANES-1:0][OUT_WIDTH-1:0] w_res;
  logic [LANES-1:0]                w_sat;
  logic [LANES-1:0][OUT_WIDTH-1:0] r_out_data;
  logic [LANES-1:0]                r_out_sat;

  assign w_s1_adv  = ~r_s2_vld | out_prdy;
  assign in_prdy   = ~r_s1_vld | w_s1_adv;
  assign w_s1_load = in_pvld & in_prdy;
  assign w_s2_load = r_s1_vld & w_s1_adv;

  assign out_pvld = r_s2_vld;
  assign out_data = r_out_data;
  assign out_sat  = r_out_sat;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [IN_WIDTH-1:0]          w_x;
    logic [SHIFT_WIDTH-1:0]       w_s;
    logic signed [C_QW-1:0]       w_xe;
    logic signed [C_QW+IN_WIDTH-1:0] w_sh;
    logic                         w_inc;
    logic [C_RW-1:0]              w_r;
    logic                         w_fit_s;
    logic                         w_fit_u;
    logic [OUT_WIDTH-1:0]         w_lres;
    logic                         w_lsat;

    assign w_x  = in_data[gi*IN_WIDTH +: IN_WIDTH];
    assign w_s  = in_shift[gi*SHIFT_WIDTH +: SHIFT_WIDTH];
    assign w_xe = {~in_unsigned & w_x[IN_WIDTH-1], w_x};
    // Zero fraction bits below the binary point: one arithmetic shift yields
    // floor(x/2^s) on top and the discarded bits (guide + sticky) underneath.
    assign w_sh = $signed({w_xe, {IN_WIDTH{1'b0}}}) >>> w_s;

    assign w_q[gi]      = w_sh[C_QW+IN_WIDTH-1 -: C_QW];
    assign w_guide[gi]  = w_sh[IN_WIDTH-1];
    assign w_sticky[gi] = |w_sh[IN_WIDTH-2:0];
    assign w_neg[gi]    = w_xe[C_QW-1];
    assign w_oor[gi]    = (int'(w_s) >= IN_WIDTH);

    // Half away from zero: a negative exact half stays at the floor.
    assign w_inc   = r_s1_rnd & r_guide[gi] & (~r_neg[gi] | r_sticky[gi]);
    assign w_r     = {r_q[gi][C_QW-1], r_q[gi]} + C_RW'(w_inc);
    assign w_fit_s = (&w_r[C_RW-1:OUT_WIDTH-1]) | ~(|w_r[C_RW-1:OUT_WIDTH-1]);
    assign w_fit_u = ~(|w_r[C_RW-1:OUT_WIDTH]);

    // Clamp the rounded quotient into the output range of the beat's mode
    always_comb begin
      w_lres = w_r[OUT_WIDTH-1:0];
      w_lsat = 1'b0;
      if (r_oor[gi]) begin
        w_lres = '0;
      end else if (r_s1_uns) begin
        if (!w_fit_u) begin
          w_lres = '1;
          w_lsat = 1'b1;
        end
      end else if (!w_fit_s) begin
        w_lres = {w_r[C_RW-1], {(OUT_WIDTH-1){~w_r[C_RW-1]}}};
        w_lsat = 1'b1;
      end
    end

    assign w_res[gi] = w_lres;
    assign w_sat[gi] = w_lsat;
  end

  // Stage 1: capture shifted lanes and beat modes on each input transfer
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_s1_vld <= 1'b0;
      r_s1_uns <= 1'b0;
      r_s1_rnd <= 1'b0;
      r_q      <= '0;
      r_guide  <= '0;
      r_sticky <= '0;
      r_neg    <= '0;
      r_oor    <= '0;
    end else begin
      if (in_prdy) begin
        r_s1_vld <= in_pvld;
      end
      if (w_s1_load) begin
        r_s1_uns <= in_unsigned;
        r_s1_rnd <= in_round_en;
        r_q      <= w_q;
        r_guide  <= w_guide;
        r_sticky <= w_sticky;
        r_neg    <= w_neg;
        r_oor    <= w_oor;
      end
    end
  end

  // Stage 2: register rounded/saturated results; hold them while stalled
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_s2_vld   <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s2_vld <= r_s1_vld;
      end
      if (w_s2_load) begin
        r_out_data <= w_res;
        r_out_sat  <= w_sat;
      end
    end
  end

`ifdef NVDLA_HLS_SHIFTRIGHTSU_SAT_CNT_EN
  localparam int C_PW = $clog2(LANES + 1);

  logic [C_PW-1:0]          w_pop;
  logic [SAT_CNT_WIDTH:0]   w_sum;
  logic [SAT_CNT_WIDTH-1:0] r_sat_cnt;

  // Popcount of saturated lanes in the beat currently presented at the output
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + C_PW'(r_out_sat[i]);
    end
    w_sum = {1'b0, r_sat_cnt} + (SAT_CNT_WIDTH+1)'(w_pop);
  end

  // Clear wins over a coincident increment; the count holds at all-ones
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_sat_cnt <= '0;
    end else if (sat_cnt_clr) begin
      r_sat_cnt <= '0;
    end else if (r_s2_vld & out_prdy) begin
      r_sat_cnt <= w_sum[SAT_CNT_WIDTH] ? '1 : w_sum[SAT_CNT_WIDTH-1:0];
    end
  end

  assign sat_cnt = r_sat_cnt;
`else
  logic w_unused_sat_cnt_clr;
  assign w_unused_sat_cnt_clr = sat_cnt_clr;
  assign sat_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nvdla_hls_shiftrightsu_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_nvdla_hls_shiftrightsu_pipe                              |
// | Purpose  : self-checking bench for nvdla_hls_shiftrightsu_pipe         |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_nvdla_hls_shiftrightsu_pipe;
  localparam int LN  = 4;
  localparam int IW  = 49;
  localparam int OW  = 32;
  localparam int SW  = 6;
  localparam int SCW = 32;
  localparam int M_RDY  = 0;
  localparam int M_RAND = 1;
  localparam int M_HOLD = 2;

  typedef struct packed {
    logic [LN*OW-1:0] d;
    logic [LN-1:0]    s;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_pvld;
  logic              in_prdy;
  logic [LN*IW-1:0]  in_data;
  logic [LN*SW-1:0]  in_shift;
  logic              in_unsigned;
  logic              in_round_en;
  logic              out_pvld;
  logic              out_prdy;
  logic [LN*OW-1:0]  out_data;
  logic [LN-1:0]     out_sat;
  logic              sat_cnt_clr;
  logic [SCW-1:0]    sat_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   mode   = M_RDY;
  exp_t q[$];

  nvdla_hls_shiftrightsu_pipe #(
    .LANES(LN), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .SAT_CNT_WIDTH(SCW)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .in_pvld         (in_pvld),
    .in_prdy         (in_prdy),
    .in_data         (in_data),
    .in_shift        (in_shift),
    .in_unsigned     (in_unsigned),
    .in_round_en     (in_round_en),
    .out_pvld        (out_pvld),
    .out_prdy        (out_prdy),
    .out_data        (out_data),
    .out_sat         (out_sat),
    .sat_cnt_clr     (sat_cnt_clr),
    .sat_cnt         (sat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference lane: floor division, remainder-based rounding, range clamp
  function automatic void model_lane(input logic [IW-1:0] raw, input int s, input bit uns,
                                     input bit rnd, output logic [OW-1:0] d, output logic sat);
    longint     x, qq, r, half, lo, hi;
    logic [63:0] t;
    t   = uns ? {{(64-IW){1'b0}}, raw} : {{(64-IW){raw[IW-1]}}, raw};
    x   = longint'(t);
    d   = '0;
    sat = 1'b0;
    if (s < IW) begin
      qq   = x >>> s;
      r    = x - (qq <<< s);
      half = (s > 0) ? (longint'(1) <<< (s - 1)) : longint'(0);
      if (rnd && s > 0 && (r > half || (r == half && x >= 0))) qq = qq + 1;
      lo = uns ? longint'(0) : -(longint'(1) <<< (OW - 1));
      hi = uns ? (longint'(1) <<< OW) - 1 : (longint'(1) <<< (OW - 1)) - 1;
      if (qq > hi) begin
        qq = hi; sat = 1'b1;
      end else if (qq < lo) begin
        qq = lo; sat = 1'b1;
      end
      d = qq[OW-1:0];
    end
  endfunction

  function automatic logic [LN*IW-1:0] pack_x(input longint a, input longint b,
                                              input longint c, input longint e);
    return {e[IW-1:0], c[IW-1:0], b[IW-1:0], a[IW-1:0]};
  endfunction

  function automatic logic [LN*SW-1:0] pack_s(input int a, input int b, input int c, input int e);
    return {SW'(e), SW'(c), SW'(b), SW'(a)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (mode)
      M_RDY:   out_prdy = 1'b1;
      M_RAND:  out_prdy = 1'($urandom_range(0, 1));
      default: out_prdy = 1'b0;
    endcase
  endtask

  task automatic idle();
    in_pvld = 1'b0;
  endtask

  // Present one beat, push its expected result when accepted, leave in_pvld high
  task automatic send(input logic [LN*IW-1:0] d, input logic [LN*SW-1:0] s,
                      input bit uns, input bit rnd);
    exp_t        e;
    logic [OW-1:0] ld;
    logic        ls;
    bit          ok = 1'b0;
    in_pvld = 1'b1; in_data = d; in_shift = s; in_unsigned = uns; in_round_en = rnd;
    for (int i = 0; i < LN; i++) begin
      model_lane(d[i*IW +: IW], int'(s[i*SW +: SW]), uns, rnd, ld, ls);
      e.d[i*OW +: OW] = ld;
      e.s[i]          = ls;
    end
    for (int w = 0; w < 200 && !ok; w++) begin
      #1;
      if (in_prdy) begin
        q.push_back(e);
        ok = 1'b1;
      end
      tick();
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL send_accept observed=%0d expected=%0d", ok, 1);
    end
  endtask

  task automatic drain();
    for (int w = 0; w < 500 && (q.size() != 0 || out_pvld); w++) tick();
    chk("drain_empty", {127'd0, (q.size() == 0 && !out_pvld)}, 128'd1);
  endtask

  // Directed beat with literal expectations; also checks 2-cycle latency
  task automatic directed(input string tag, input logic [LN*IW-1:0] d, input logic [LN*SW-1:0] s,
                          input bit uns, input bit rnd, input logic [LN*OW-1:0] ed,
                          input logic [LN-1:0] es);
    send(d, s, uns, rnd);
    idle();
    chk({tag, "_lat_pvld0"}, {127'd0, out_pvld}, 128'd0);
    tick();
    chk({tag, "_lat_pvld1"}, {127'd0, out_pvld}, 128'd1);
    chk({tag, "_data"}, {{(128-LN*OW){1'b0}}, out_data}, {{(128-LN*OW){1'b0}}, ed});
    chk({tag, "_sat"}, {{(128-LN){1'b0}}, out_sat}, {{(128-LN){1'b0}}, es});
    tick();
  endtask

  // Output monitor: scoreboard compare on transfer, stability while stalled
  logic [LN*OW-1:0] prev_d;
  logic [LN-1:0]    prev_s;
  bit               prev_stall = 1'b0;
  exp_t             mexp;
  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        assert (out_pvld === 1'b1 && out_data === prev_d && out_sat === prev_s) else begin
          errors++;
          $error("FAIL stall_stable observed=%b/%h/%b expected=1/%h/%b",
                 out_pvld, out_data, out_sat, prev_d, prev_s);
        end
      end
      prev_stall = out_pvld && !out_prdy;
      prev_d     = out_data;
      prev_s     = out_sat;
      if (out_pvld === 1'b1 && out_prdy === 1'b1) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL sb_unexpected observed=%h expected=none", out_data);
        end
        if (q.size() != 0) begin
          mexp = q.pop_front();
          checks++;
          assert (out_data === mexp.d && out_sat === mexp.s) else begin
            errors++;
            $error("FAIL sb_data observed=%h/%b expected=%h/%b", out_data, out_sat, mexp.d, mexp.s);
          end
        end
      end
    end
  end

  initial begin
    int start;
    logic [LN*IW-1:0] rd;
    logic [LN*SW-1:0] rs;
    logic [63:0]      r64;
    logic [IW-1:0]    lane;
    bit               uns;
    rstn = 1'b0; in_pvld = 1'b0; in_data = '0; in_shift = '0;
    in_unsigned = 1'b0; in_round_en = 1'b0; out_prdy = 1'b1; sat_cnt_clr = 1'b0;
    mode = M_RDY;
    repeat (3) tick();
    chk("rst_pvld", {127'd0, out_pvld}, 128'd0);
    chk("rst_data", {{(128-LN*OW){1'b0}}, out_data}, 128'd0);
    chk("rst_sat", {{(128-LN){1'b0}}, out_sat}, 128'd0);
    chk("rst_satcnt", {{(128-SCW){1'b0}}, sat_cnt}, 128'd0);
    rstn = 1'b1;
    #1;
    chk("rst_prdy", {127'd0, in_prdy}, 128'd1);
    tick();

    directed("sgn_rnd", pack_x(7, -5, 64'h100_0000_0000, -64'sh100_0000_0000),
             pack_s(2, 1, 0, 0), 1'b0, 1'b1,
             {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0002}, 4'b1100);
    directed("sgn_trunc", pack_x(7, -5, 64'h100_0000_0000, -64'sh100_0000_0000),
             pack_s(2, 1, 0, 0), 1'b0, 1'b0,
             {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001}, 4'b1100);
    directed("sgn_edge", pack_x(64'h7FFF_FFFF, 64'hFFFF_FFFF, -1, 64'h100_0000_0000),
             pack_s(0, 1, 49, 63), 1'b0, 1'b1,
             {32'h0, 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, 4'b0010);
    directed("uns_edge", pack_x(64'h2_0000_0000, 64'h2_0000_0000, 64'h1_FFFF_FFFF_FFFF, 64'h1_FFFF_FFFF_FFFF),
             pack_s(0, 2, 49, 63), 1'b1, 1'b1,
             {32'h0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF}, 4'b0001);
`ifndef NVDLA_HLS_SHIFTRIGHTSU_SAT_CNT_EN
    chk("satcnt_off", {{(128-SCW){1'b0}}, sat_cnt}, 128'd0);
`endif

    // Back-to-back acceptance with the output always ready
    start = cyc;
    for (int b = 0; b < 8; b++)
      send(pack_x(b * 1000 + 3, -b * 77, 64'h3_0000_0000 + b, b), pack_s(b, 3, 1, 0), 1'b0, 1'b1);
    chk("throughput", 128'(cyc - start), 128'd8);
    idle();
    drain();

    // Random stream against a randomly stalling consumer
    mode = M_RAND;
    for (int b = 0; b < 100; b++) begin
      uns = 1'($urandom_range(0, 1));
      for (int i = 0; i < LN; i++) begin
        r64  = {$urandom, $urandom};
        lane = r64[IW-1:0] >> (IW - int'($urandom_range(1, IW)));
        if (!uns && $urandom_range(0, 1) == 1) lane = -lane;
        rd[i*IW +: IW] = lane;
        rs[i*SW +: SW] = ($urandom_range(0, 8) == 0) ? SW'($urandom_range(IW, 63))
                                                     : SW'($urandom_range(0, 20));
      end
      send(rd, rs, uns, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        tick();
      end
    end
    idle();
    mode = M_RDY;
    drain();

    // Reset with two beats in flight drops them
    mode = M_HOLD;
    tick();
    send(pack_x(1, 2, 3, 4), pack_s(0, 0, 0, 0), 1'b0, 1'b0);
    send(pack_x(5, 6, 7, 8), pack_s(0, 0, 0, 0), 1'b0, 1'b0);
    idle();
    rstn = 1'b0;
    tick();
    chk("mid_rst_pvld", {127'd0, out_pvld}, 128'd0);
    chk("mid_rst_data", {{(128-LN*OW){1'b0}}, out_data}, 128'd0);
    chk("mid_rst_sat", {{(128-LN){1'b0}}, out_sat}, 128'd0);
    q.delete();
    rstn = 1'b1;
    mode = M_RDY;
    #1;
    chk("mid_rst_prdy", {127'd0, in_prdy}, 128'd1);
    tick();

`ifdef NVDLA_HLS_SHIFTRIGHTSU_SAT_CNT_EN
    sat_cnt_clr = 1'b1;
    tick();
    sat_cnt_clr = 1'b0;
    send(pack_x(64'h100_0000_0000, -64'sh100_0000_0000, 64'h100_0000_0000, 0),
         pack_s(0, 0, 0, 0), 1'b0, 1'b0);
    idle();
    drain();
    chk("satcnt_inc3", {{(128-SCW){1'b0}}, sat_cnt}, 128'd3);
    mode = M_HOLD;
    tick();
    send(pack_x(64'h100_0000_0000, -64'sh100_0000_0000, 64'h100_0000_0000, 0),
         pack_s(0, 0, 0, 0), 1'b0, 1'b0);
    idle();
    tick();
    tick();
    out_prdy = 1'b1;
    sat_cnt_clr = 1'b1;
    mode = M_RDY;
    tick();
    sat_cnt_clr = 1'b0;
    chk("satcnt_clr_wins", {{(128-SCW){1'b0}}, sat_cnt}, 128'd0);
    drain();
`endif

    chk("final_queue", 128'(q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nvdla_hls_shiftrightsu_pipe.md
Name: nvdla_hls_shiftrightsu_pipe

Overview:
- Multi-lane, pipelined right-shift with rounding and saturation, parametrised in lane count, widths and signedness.
- Converts wide accumulator or intermediate data (e.g. 49b) to narrower output precision (e.g. 32b) inside NVDLA datapaths.
- Full-throughput valid/ready pipe with backpressure.
- Adds per-beat signed/unsigned mode and round/truncate mode, which the single-lane combinational shifter lacks.

Parameters:
- LANES, 4, number of independent lanes per beat
- IN_WIDTH, 49, input data width per lane
- OUT_WIDTH, 32, output data width per lane (OUT_WIDTH < IN_WIDTH)
- SHIFT_WIDTH, 6, shift amount width per lane
- SAT_CNT_WIDTH, 32, saturation counter width (used only with optional feature)

Ports:
- nvdla_core_clk  in  1  core clock; all logic on rising edge
- nvdla_core_rstn  in  1  synchronous active-low reset
- in_pvld  in  1  input beat valid
- in_prdy  out  1  input beat ready
- in_data  in  LANES*IN_WIDTH  lane i at [i*IN_WIDTH +: IN_WIDTH]
- in_shift  in  LANES*SHIFT_WIDTH  per-lane shift amount
- in_unsigned  in  1  1 = data unsigned; 0 = two's complement; per beat
- in_round_en  in  1  1 = round half away from zero; 0 = truncate (floor); per beat
- out_pvld  out  1  output beat valid
- out_prdy  in  1  output beat ready
- out_data  out  LANES*OUT_WIDTH  lane i at [i*OUT_WIDTH +: OUT_WIDTH]
- out_sat  out  LANES  per-lane flag: lane result was saturated
- sat_cnt_clr  in  1  clear saturation counter (optional feature only)
- sat_cnt  out  SAT_CNT_WIDTH  saturation event count (optional feature only)

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of nvdla_core_clk.
  - Reset clears both stage valids; out_pvld=0, out_data=0, out_sat=0, sat_cnt=0.
  - in_prdy=1 from the first cycle after reset is released.
  - A beat in flight at reset is dropped.
- Pipeline: 2 register stages.
  - S1 registers per lane: shifted value, guide bit, sticky OR, sign, out-of-range flag, plus the mode bits.
  - S2 registers rounded and saturated out_data and out_sat.
- Latency: 2 cycles from in_pvld&in_prdy to out_pvld when out_prdy=1.
- Throughput: 1 beat/cycle with out_prdy held high.
- Handshake:
  - Transfer occurs when valid&ready are both high.
  - in_prdy = ~s1_vld | s1_adv, where s1_adv = ~s2_vld | out_prdy.
  - No combinational path from in_pvld to in_prdy.
  - out_data and out_sat stay stable while out_pvld=1 and out_prdy=0.
  - No beat is lost or duplicated.
- Arithmetic per lane. Let x be in_data as signed or unsigned per in_unsigned, and s = in_shift.
  - If s >= IN_WIDTH, the result is 0 and out_sat=0, in both modes.
  - Otherwise q = floor(x / 2^s).
  - Rounding (in_round_en=1): add 1 when the guide bit is set and (x >= 0 or sticky != 0), i.e. half away from zero. Truncate (in_round_en=0): q unchanged.
  - Sticky for s=0 is 0.
- Saturation, evaluated after rounding:
  - Signed: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Unsigned: clamp to [0, 2^OUT_WIDTH-1].
  - Rounding carry-out into an overflow counts as saturation.
  - out_sat=1 if and only if the clamp changed the value.
- Lanes are fully independent; mode bits are shared across the lanes of one beat.

Optional Feature:
- Macro: NVDLA_HLS_SHIFTRIGHTSU_SAT_CNT_EN
- Defined:
  - sat_cnt increments on each out_pvld&out_prdy by popcount(out_sat).
  - sat_cnt sticks at all-ones and does not wrap.
  - sat_cnt_clr=1 sets sat_cnt to 0 next cycle. A clear takes priority over a simultaneous increment, which is lost.
- Undefined:
  - No counter logic is built.
  - sat_cnt is driven 0; sat_cnt_clr is ignored.

Test Plan:
- Signed, round_en=1, lane0 x=7 s=2 -> out 2; same with round_en=0 -> out 1. Lane1 x=-5 s=1 -> 0xFFFFFFFD (-3) in both modes; out_sat=0.
- Signed, x=2^40 s=0 -> 0x7FFFFFFF, out_sat=1. x=-2^40 s=0 -> 0x80000000, out_sat=1. x=2^31-1 s=0 -> 0x7FFFFFFF, out_sat=0.
- Unsigned, x=2^33 s=0 -> 0xFFFFFFFF, out_sat=1. x=2^33 s=2 -> 0x80000000, out_sat=0. Signed x=2^32-1 s=1 round -> 0x7FFFFFFF, out_sat=1 (rounding carry saturates).
- s=49 and s=63 with any x -> 0, out_sat=0, in both modes.
- Streaming 100 random beats with random out_prdy (50%) -> outputs match model in order; no drop or duplication; data stable while stalled. out_prdy=1 -> output 2 cycles after acceptance at 1 beat/cycle.
- Reset asserted with 2 beats in flight -> out_pvld=0 next cycle, outputs 0, in_prdy=1. With macro: 3 saturated lanes in one beat -> sat_cnt += 3. Clear coincident with increment -> sat_cnt=0.
